// File: rtl/emergency_request_conditioner.sv
// -----------------------------------------------------------------------------
// emergency_request_conditioner
//
// Front-end for traffic_light_controller. Takes raw, asynchronous, possibly
// bouncy emergency-vehicle detector inputs and turns them into clean,
// mutually exclusive, minimum-length requests. Right has priority over left.
//
// Inputs pass through a 2-flop synchronizer and then a per-input debouncer.
// An arbiter FSM (IDLE / GRANT_R / GRANT_L / GAP) holds each grant for at
// least MIN_HOLD cycles. It lets right preempt left with a same-edge swap,
// and inserts GAP dead cycles between non-preemptive grants.
//
// Parameters:
//   DEBOUNCE  consecutive disagreeing cycles before a debounced level flips
//   MIN_HOLD  minimum grant length in cycles (matches controller T_EM)
//   GAP       dead cycles between two non-preemptive grants
//
// Ports:
//   clk              system clock (same as the controller)
//   reset            asynchronous, active-low reset
//   raw_left         unsynchronized left detector
//   raw_right        unsynchronized right detector
//   Emergency_Left   registered left request to the controller
//   Emergency_Right  registered right request to the controller
//   em_active        registered OR of both grants
//   grant_count      saturating count of grant entries (including re-grants)
// -----------------------------------------------------------------------------
module emergency_request_conditioner #(
    parameter int DEBOUNCE = 3,
    parameter int MIN_HOLD = 9,
    parameter int GAP      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_left,
    input  logic       raw_right,
    output logic       Emergency_Left,
    output logic       Emergency_Right,
    output logic       em_active,
    output logic [7:0] grant_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT_R = 2'b01,
        ST_GRANT_L = 2'b10,
        ST_GAP     = 2'b11
    } state_t;

    localparam int DB_W   = $clog2(DEBOUNCE + 1);
    localparam int HOLD_W = $clog2(MIN_HOLD + 1);
    localparam int GAP_W  = $clog2(GAP + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP - 1);

    // One debouncer step: returns {flip, next_count}. The count restarts
    // whenever the synchronized input agrees with the debounced level, so a
    // flip needs DEBOUNCE consecutive disagreeing samples.
    function automatic logic [DB_W:0] debounce_step(
        input logic            s,
        input logic            db,
        input logic [DB_W-1:0] cnt
    );
        logic [DB_W:0] res;
        if (s == db) begin
            res = {1'b0, {DB_W{1'b0}}};
        end else if (cnt == DB_LAST) begin
            res = {1'b1, {DB_W{1'b0}}};
        end else begin
            res = {1'b0, cnt + DB_W'(1)};
        end
        return res;
    endfunction

    logic [1:0]        sync_l_r, sync_r_r;
    logic              s_left_s, s_right_s;
    logic              db_left_r, db_right_r;
    logic [DB_W-1:0]   db_l_cnt_r, db_r_cnt_r;
    logic [DB_W-1:0]   db_l_cnt_nxt_s, db_r_cnt_nxt_s;
    logic              db_l_flip_s, db_r_flip_s;
    logic              rise_l_s, rise_r_s;
    logic              pend_l_r, pend_r_r;
    logic              pend_l_nxt_s, pend_r_nxt_s;
    state_t            state_r, state_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_nxt_s;
    logic [GAP_W-1:0]  gap_cnt_r, gap_cnt_nxt_s;
    logic              req_r_s, req_l_s;
    logic              hold_done_s, gap_done_s;
    logic              enter_r_s, enter_l_s, enter_gap_s, preempt_s;
    logic              em_left_r, em_right_r, em_active_r;
    logic [7:0]        grant_count_r, grant_count_nxt_s;

    assign s_left_s  = sync_l_r[1];
    assign s_right_s = sync_r_r[1];

    // Two-flop synchronizers for the asynchronous detector inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_l_r <= 2'b00;
            sync_r_r <= 2'b00;
        end else begin
            sync_l_r <= {sync_l_r[0], raw_left};
            sync_r_r <= {sync_r_r[0], raw_right};
        end
    end

    // Debouncer next-state for both inputs, plus the rising-edge events.
    always_comb begin
        {db_l_flip_s, db_l_cnt_nxt_s} = debounce_step(s_left_s, db_left_r, db_l_cnt_r);
        {db_r_flip_s, db_r_cnt_nxt_s} = debounce_step(s_right_s, db_right_r, db_r_cnt_r);
        rise_l_s = db_l_flip_s & ~db_left_r;
        rise_r_s = db_r_flip_s & ~db_right_r;
    end

    // Debounced levels and their counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_left_r  <= 1'b0;
            db_right_r <= 1'b0;
            db_l_cnt_r <= {DB_W{1'b0}};
            db_r_cnt_r <= {DB_W{1'b0}};
        end else begin
            db_left_r  <= db_left_r ^ db_l_flip_s;
            db_right_r <= db_right_r ^ db_r_flip_s;
            db_l_cnt_r <= db_l_cnt_nxt_s;
            db_r_cnt_r <= db_r_cnt_nxt_s;
        end
    end

    assign req_r_s     = pend_r_r | db_right_r;
    assign req_l_s     = pend_l_r | db_left_r;
    assign hold_done_s = (hold_cnt_r >= HOLD_LAST);
    assign gap_done_s  = (gap_cnt_r >= GAP_LAST);

    // Arbiter next-state: right wins any tie; a debounced right request
    // preempts a left grant immediately, with no gap.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_r_s) begin
                    state_nxt_s = ST_GRANT_R;
                end else if (req_l_s) begin
                    state_nxt_s = ST_GRANT_L;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT_R: begin
                if (hold_done_s && !db_right_r) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_GRANT_R;
                end
            end
            ST_GRANT_L: begin
                if (db_right_r) begin
                    state_nxt_s = ST_GRANT_R;
                end else if (hold_done_s && !db_left_r) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_GRANT_L;
                end
            end
            ST_GAP: begin
                if (!gap_done_s) begin
                    state_nxt_s = ST_GAP;
                end else if (req_r_s) begin
                    state_nxt_s = ST_GRANT_R;
                end else if (req_l_s) begin
                    state_nxt_s = ST_GRANT_L;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Transition events, pending flags, hold/gap timers and grant counter.
    always_comb begin
        enter_r_s   = (state_nxt_s == ST_GRANT_R) && (state_r != ST_GRANT_R);
        enter_l_s   = (state_nxt_s == ST_GRANT_L) && (state_r != ST_GRANT_L);
        enter_gap_s = (state_nxt_s == ST_GAP) && (state_r != ST_GAP);
        preempt_s   = (state_r == ST_GRANT_L) && (state_nxt_s == ST_GRANT_R);

        // Entry clears a pending flag. This takes priority over a new rise
        // seen on that same edge, because the grant is already serving it.
        if (enter_r_s) begin
            pend_r_nxt_s = 1'b0;
        end else if (rise_r_s && (state_r != ST_GRANT_R)) begin
            pend_r_nxt_s = 1'b1;
        end else begin
            pend_r_nxt_s = pend_r_r;
        end

        // A preempted left grant stays pending and later gets a full hold.
        if (enter_l_s) begin
            pend_l_nxt_s = 1'b0;
        end else if (preempt_s) begin
            pend_l_nxt_s = 1'b1;
        end else if (rise_l_s && (state_r != ST_GRANT_L)) begin
            pend_l_nxt_s = 1'b1;
        end else begin
            pend_l_nxt_s = pend_l_r;
        end

        if (enter_r_s || enter_l_s) begin
            hold_cnt_nxt_s = {HOLD_W{1'b0}};
        end else if (((state_r == ST_GRANT_R) || (state_r == ST_GRANT_L)) &&
                     (hold_cnt_r < HOLD_LAST)) begin
            hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
        end else begin
            hold_cnt_nxt_s = hold_cnt_r;
        end

        if (enter_gap_s) begin
            gap_cnt_nxt_s = {GAP_W{1'b0}};
        end else if ((state_r == ST_GAP) && (gap_cnt_r < GAP_LAST)) begin
            gap_cnt_nxt_s = gap_cnt_r + GAP_W'(1);
        end else begin
            gap_cnt_nxt_s = gap_cnt_r;
        end

        if ((enter_r_s || enter_l_s) && (grant_count_r != 8'hFF)) begin
            grant_count_nxt_s = grant_count_r + 8'd1;
        end else begin
            grant_count_nxt_s = grant_count_r;
        end
    end

    // Arbiter state, bookkeeping, and outputs decoded from the next state
    // so the grant lines change on the same edge as the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            pend_l_r      <= 1'b0;
            pend_r_r      <= 1'b0;
            hold_cnt_r    <= {HOLD_W{1'b0}};
            gap_cnt_r     <= {GAP_W{1'b0}};
            grant_count_r <= 8'd0;
            em_left_r     <= 1'b0;
            em_right_r    <= 1'b0;
            em_active_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            pend_l_r      <= pend_l_nxt_s;
            pend_r_r      <= pend_r_nxt_s;
            hold_cnt_r    <= hold_cnt_nxt_s;
            gap_cnt_r     <= gap_cnt_nxt_s;
            grant_count_r <= grant_count_nxt_s;
            em_left_r     <= (state_nxt_s == ST_GRANT_L);
            em_right_r    <= (state_nxt_s == ST_GRANT_R);
            em_active_r   <= (state_nxt_s == ST_GRANT_L) || (state_nxt_s == ST_GRANT_R);
        end
    end

    assign Emergency_Left  = em_left_r;
    assign Emergency_Right = em_right_r;
    assign em_active       = em_active_r;
    assign grant_count     = grant_count_r;

endmodule
